// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 2-stage add/sub ALU between NUM_REQ requesters,
// with per-requester credits and response FIFOs steered by an ID tag pipeline.

module alu_arbiter_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_result
);
   localparam logic [1:0] OP_ADD = 2'd1;
   localparam logic [1:0] OP_SUB = 2'd2;

   // Two's-complement wrap: the result keeps only the low WIDTH bits.
   function automatic logic signed [WIDTH-1:0] alu_calc(
      input logic [1:0]              op,
      input logic signed [WIDTH-1:0] a,
      input logic signed [WIDTH-1:0] b
   );
      case (op)
         OP_ADD:  alu_calc = a + b;
         OP_SUB:  alu_calc = a - b;
         default: alu_calc = '0;
      endcase
   endfunction

   logic                    vld_p0_q, vld_p0_d;
   logic [1:0]              op_p0_q, op_p0_d;
   logic signed [WIDTH-1:0] a_p0_q, a_p0_d;
   logic signed [WIDTH-1:0] b_p0_q, b_p0_d;
   logic                    vld_p1_q, vld_p1_d;
   logic signed [WIDTH-1:0] res_p1_q, res_p1_d;

   always_comb begin
      vld_p0_d = in_valid;
      op_p0_d  = in_op;
      a_p0_d   = $signed(in_a);
      b_p0_d   = $signed(in_b);
      vld_p1_d = vld_p0_q;
      res_p1_d = alu_calc(op_p0_q, a_p0_q, b_p0_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0_q <= 1'b0;
         vld_p1_q <= 1'b0;
      end else begin
         vld_p0_q <= vld_p0_d;
         vld_p1_q <= vld_p1_d;
      end
   end

   // Stage p0 captures operands, stage p1 holds the result.
   always_ff @(posedge clk) begin
      op_p0_q  <= op_p0_d;
      a_p0_q   <= a_p0_d;
      b_p0_q   <= b_p0_d;
      res_p1_q <= res_p1_d;
   end

   assign out_valid  = vld_p1_q;
   assign out_result = $unsigned(res_p1_q);
endmodule

module alu_arbiter #(
   parameter int WIDTH     = 8,
   parameter int NUM_REQ   = 4,
   parameter int RSP_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [2*NUM_REQ-1:0]     req_op,
   input  logic [WIDTH*NUM_REQ-1:0] req_a,
   input  logic [WIDTH*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]       rsp_valid,
   input  logic [NUM_REQ-1:0]       rsp_ready,
   output logic [WIDTH*NUM_REQ-1:0] rsp_data,
   output logic                     busy
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(RSP_DEPTH - 1)) ptr_inc = '0;
      else                            ptr_inc = p + PTR_W'(1);
   endfunction

   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic             tag_vld_p0_q, tag_vld_p0_d;
   logic [ID_W-1:0]  tag_id_p0_q, tag_id_p0_d;
   logic             tag_vld_p1_q, tag_vld_p1_d;
   logic [ID_W-1:0]  tag_id_p1_q, tag_id_p1_d;

   logic [CNT_W-1:0] credit_q [NUM_REQ];
   logic [CNT_W-1:0] credit_d [NUM_REQ];
   logic [CNT_W-1:0] count_q  [NUM_REQ];
   logic [CNT_W-1:0] count_d  [NUM_REQ];
   logic [PTR_W-1:0] rd_ptr_q [NUM_REQ];
   logic [PTR_W-1:0] rd_ptr_d [NUM_REQ];
   logic [PTR_W-1:0] wr_ptr_q [NUM_REQ];
   logic [PTR_W-1:0] wr_ptr_d [NUM_REQ];
   logic [WIDTH-1:0] head_q   [NUM_REQ];
   logic [WIDTH-1:0] head_d   [NUM_REQ];
   logic [WIDTH-1:0] mem_q    [NUM_REQ][RSP_DEPTH];
   logic [WIDTH-1:0] mem_d    [NUM_REQ][RSP_DEPTH];

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] pop;
   logic [NUM_REQ-1:0] push;
   logic               grant_vld;
   logic [ID_W-1:0]    grant_id;
   int unsigned        arb_idx;

   logic               alu_in_valid;
   logic [1:0]         alu_in_op;
   logic [WIDTH-1:0]   alu_in_a;
   logic [WIDTH-1:0]   alu_in_b;
   logic               alu_out_valid;
   logic [WIDTH-1:0]   alu_out_result;

   // Round-robin search starting just above the last granted index.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      arb_idx   = 0;
      for (int i = 0; i < NUM_REQ; i++)
         eligible[i] = req_valid[i] && (credit_q[i] != '0);
      for (int k = 1; k <= NUM_REQ; k++) begin
         arb_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!grant_vld && eligible[arb_idx]) begin
            grant_vld = 1'b1;
            grant_id  = ID_W'(arb_idx);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         req_ready[i] = grant_vld && (grant_id == ID_W'(i));
      alu_in_valid = grant_vld;
      alu_in_op    = 2'b00;
      alu_in_a     = '0;
      alu_in_b     = '0;
      if (grant_vld) begin
         alu_in_op = req_op[2*int'(grant_id) +: 2];
         alu_in_a  = req_a[WIDTH*int'(grant_id) +: WIDTH];
         alu_in_b  = req_b[WIDTH*int'(grant_id) +: WIDTH];
      end
      rr_ptr_d     = grant_vld ? grant_id : rr_ptr_q;
      tag_vld_p0_d = grant_vld;
      tag_id_p0_d  = grant_id;
      tag_vld_p1_d = tag_vld_p0_q;
      tag_id_p1_d  = tag_id_p0_q;
   end

   alu_arbiter_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (alu_in_valid),
      .in_op      (alu_in_op),
      .in_a       (alu_in_a),
      .in_b       (alu_in_b),
      .out_valid  (alu_out_valid),
      .out_result (alu_out_result)
   );

   // Credits and response FIFOs; the head register is kept ready for rsp_data.
   always_comb begin
      credit_d = credit_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      head_d   = head_q;
      mem_d    = mem_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         pop[i]  = rsp_ready[i] && (count_q[i] != '0);
         push[i] = alu_out_valid && (tag_id_p1_q == ID_W'(i));

         case ({req_ready[i], pop[i]})
            2'b10:   credit_d[i] = credit_q[i] - CNT_W'(1);
            2'b01:   credit_d[i] = credit_q[i] + CNT_W'(1);
            default: credit_d[i] = credit_q[i];
         endcase

         case ({push[i], pop[i]})
            2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
            2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
            default: count_d[i] = count_q[i];
         endcase

         if (push[i]) begin
            mem_d[i][wr_ptr_q[i]] = alu_out_result;
            wr_ptr_d[i]           = ptr_inc(wr_ptr_q[i]);
         end
         if (pop[i])
            rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);

         if (push[i] && ((count_q[i] == '0) || (pop[i] && count_q[i] == CNT_W'(1))))
            head_d[i] = alu_out_result;
         else if (pop[i] && count_q[i] == CNT_W'(1))
            head_d[i] = '0;
         else if (pop[i])
            head_d[i] = mem_q[i][ptr_inc(rd_ptr_q[i])];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q     <= ID_W'(NUM_REQ - 1);
         tag_vld_p0_q <= 1'b0;
         tag_id_p0_q  <= '0;
         tag_vld_p1_q <= 1'b0;
         tag_id_p1_q  <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            credit_q[i] <= CNT_W'(RSP_DEPTH);
            count_q[i]  <= '0;
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            head_q[i]   <= '0;
         end
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         tag_vld_p0_q <= tag_vld_p0_d;
         tag_id_p0_q  <= tag_id_p0_d;
         tag_vld_p1_q <= tag_vld_p1_d;
         tag_id_p1_q  <= tag_id_p1_d;
         credit_q     <= credit_d;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         head_q       <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i]                 = (count_q[i] != '0);
         rsp_data[WIDTH*i +: WIDTH]   = head_q[i];
      end
      busy = tag_vld_p0_q || tag_vld_p1_q || (|rsp_valid);
   end
endmodule
